// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_mem_pkg
// Brief   : Shared definitions for the data-memory responder: load/store size
//           codes, responder FSM states and the byte-lane mask helper.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

  // funct3-style access size codes
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Responder FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Byte lanes touched by an access of the given size at the given offset.
  // Illegal size codes select no lanes.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_B, SZ_BU: mask = 4'b0001 << addr_lo;
      SZ_H, SZ_HU: mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_W:        mask = 4'b1111;
      default:     mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module  : mem_lane_align
// Brief   : Combinational lane alignment for 32-bit data memory accesses.
//           Extracts and extends load data, replicates store data across
//           lanes, builds the byte write mask and flags illegal accesses.
// Revision: 1.0 - initial release
// ============================================================================
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] rdata_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] wr_word,
  output logic [3:0]  wr_mask,
  output logic        err
);

  logic [31:0] w_shifted;

  assign w_shifted = rdata_word >> {addr_lo, 3'b000};

  // Legality: misaligned halves/words, unused size codes, unsigned store codes
  always_comb begin
    err = 1'b0;
    case (size)
      SZ_B:    err = 1'b0;
      SZ_H:    err = addr_lo[0];
      SZ_W:    err = (addr_lo != 2'b00);
      SZ_BU:   err = we;
      SZ_HU:   err = we | addr_lo[0];
      default: err = 1'b1;
    endcase
  end

  // Load extraction with sign or zero extension
  always_comb begin
    load_data = 32'h0;
    case (size)
      SZ_B:    load_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
      SZ_BU:   load_data = {24'h0, w_shifted[7:0]};
      SZ_H:    load_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
      SZ_HU:   load_data = {16'h0, w_shifted[15:0]};
      SZ_W:    load_data = rdata_word;
      default: load_data = 32'h0;
    endcase
  end

  // Store data replicated into every lane; the mask picks the live ones
  always_comb begin
    wr_word = wdata;
    case (size)
      SZ_B:    wr_word = {4{wdata[7:0]}};
      SZ_H:    wr_word = {2{wdata[15:0]}};
      default: wr_word = wdata;
    endcase
    wr_mask = (we && !err) ? lane_mask(size, addr_lo) : 4'b0000;
  end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_responder
// Brief   : Memory-side responder for the CPU load/store interface. One
//           request at a time over valid/ready, fixed access latency,
//           byte/half/word stores with lane masking, extended loads, and a
//           response over a second valid/ready pair.
// Revision: 1.0 - initial release
// ============================================================================
module data_mem_responder
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_size,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int         c_depth    = 2 ** (ADDR_W - 2);
  localparam logic [3:0] c_cnt_init = 4'(LATENCY - 1);

  state_t            r_state;
  state_t            w_next;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_size;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_err;
  logic [31:0]       r_mem [c_depth];

  logic              w_accept;
  logic              w_access;
  logic              w_rsp_done;
  logic [31:0]       w_rd_word;
  logic [31:0]       w_load_data;
  logic [31:0]       w_wr_word;
  logic [3:0]        w_wr_mask;
  logic              w_err;

  assign w_accept   = req_valid && req_ready;
  assign w_rsp_done = rsp_valid && rsp_ready;
  // The counter runs LATENCY-1 down to 0 over WAIT; the access fires on the
  // edge leaving WAIT, so the response appears exactly LATENCY edges after
  // the accept edge for every legal LATENCY including 1.
  assign w_access   = (r_state == ST_WAIT) && (r_cnt == 4'd0);
  assign w_rd_word  = r_mem[r_addr[ADDR_W-1:2]];
  assign rsp_rdata  = r_rsp_rdata;
  assign rsp_err    = r_rsp_err;

  mem_lane_align u_align (
    .we         (r_we),
    .addr_lo    (r_addr[1:0]),
    .size       (r_size),
    .rdata_word (w_rd_word),
    .wdata      (r_wdata),
    .load_data  (w_load_data),
    .wr_word    (w_wr_word),
    .wr_mask    (w_wr_mask),
    .err        (w_err)
  );

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (r_cnt == 4'd0) w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Request capture, latency counter and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_size      <= 3'b000;
      r_wdata     <= 32'h0;
      r_rsp_rdata <= 32'h0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_size  <= req_size;
        r_wdata <= req_wdata;
        r_cnt   <= c_cnt_init;
      end else if (r_state == ST_WAIT && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_access) begin
        r_rsp_rdata <= (w_err || r_we) ? 32'h0 : w_load_data;
        r_rsp_err   <= w_err;
      end else if (w_rsp_done) begin
        r_rsp_rdata <= 32'h0;
        r_rsp_err   <= 1'b0;
      end
    end
  end

  // Storage write; not reset, and blocked while reset is held
  always_ff @(posedge clk) begin
    if (!rst && w_access) begin
      for (int i = 0; i < 4; i++) begin
        if (w_wr_mask[i]) r_mem[r_addr[ADDR_W-1:2]][8*i +: 8] <= w_wr_word[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire
